// File: rtl/reaction_pkg.sv
// rtl/reaction_pkg.sv - shared state encoding and default parameters for the reaction timer
package reaction_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        GO,
        DONE,
        EARLY,
        TMO
    } react_state_t;

    localparam int TICK_DIV_DEF = 100000;
    localparam int MAX_MS_DEF   = 9999;
    localparam int RT_W_DEF     = 14;

endpackage

// File: rtl/ms_tick_gen.sv
// rtl/ms_tick_gen.sv - millisecond prescaler; tick is high on the last count of each period
module ms_tick_gen
    import reaction_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/reaction_fsm.sv
// rtl/reaction_fsm.sv - reaction timer control FSM; REACT_BEST_EN adds the best_ms tracker
module reaction_fsm
    import reaction_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int MAX_MS   = MAX_MS_DEF,
    parameter int RT_W     = RT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
    input  logic            wait5_done,
    output logic            start_wait5,
    output logic            led_go,
    output logic [RT_W-1:0] rt_ms,
    output logic            rt_valid,
    output logic            early_err,
    output logic            timeout
`ifdef REACT_BEST_EN
    ,
    output logic [RT_W-1:0] best_ms
`endif
);

    localparam logic [RT_W-1:0] MAX_V  = RT_W'(MAX_MS);
    localparam logic [RT_W-1:0] MAX_M1 = RT_W'(MAX_MS - 1);

    react_state_t    state_q, state_d;
    logic [RT_W-1:0] rt_ms_q, rt_ms_d;
    logic            tick_clr;
    logic            tick;

    ms_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (tick_clr),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rt_ms_q <= '0;
        end else begin
            state_q <= state_d;
            rt_ms_q <= rt_ms_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rt_ms_d  = rt_ms_q;
        tick_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT;
                    rt_ms_d = '0;
                end
            end
            WAIT: begin
                if (stop) begin
                    state_d = EARLY;
                end else if (wait5_done) begin
                    state_d  = GO;
                    rt_ms_d  = '0;
                    tick_clr = 1'b1;
                end
            end
            GO: begin
                // The tick that reaches the limit saturates even when stop lands on it.
                if (tick && (rt_ms_q >= MAX_M1)) begin
                    rt_ms_d = MAX_V;
                    state_d = stop ? DONE : TMO;
                end else if (stop) begin
                    state_d = DONE;
                end else if (tick) begin
                    rt_ms_d = rt_ms_q + RT_W'(1);
                end
            end
            DONE, EARLY, TMO: begin
                if (start) begin
                    state_d = WAIT;
                    rt_ms_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        start_wait5 = (state_q == WAIT);
        led_go      = (state_q == GO);
        rt_valid    = (state_q == DONE);
        early_err   = (state_q == EARLY);
        timeout     = (state_q == TMO);
        rt_ms       = rt_ms_q;
    end

`ifdef REACT_BEST_EN
    logic [RT_W-1:0] best_q, best_d;

    // Compare against the value being frozen so best_ms moves together with rt_valid.
    always_comb begin
        best_d = best_q;
        if ((state_q == GO) && (state_d == DONE) && (rt_ms_d < best_q)) begin
            best_d = rt_ms_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            best_q <= '1;
        end else begin
            best_q <= best_d;
        end
    end

    assign best_ms = best_q;
`endif

endmodule
